// File: rtl/qspi_flash_read_ctrl.sv
// Single-word QSPI Quad Output Fast Read (0x6B) controller, SPI mode 0.
// Turns one mmu read request into one flash transaction and returns a little-endian word.
module qspi_flash_read_ctrl #(
  parameter int          CLK_DIV      = 1,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          ADDR_W       = 24,
  parameter logic [7:0]  READ_CMD     = 8'h6B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  input  logic [3:0]  qspi_io_i,
  output logic [3:0]  qspi_io_o,
  output logic [3:0]  qspi_io_t,
  output logic        qspi_ck_o,
  output logic        qspi_cs_o
);

  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_BITS   = (ADDR_W > DUMMY_CYCLES) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                                      : ((DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8);
  localparam int BIT_W      = $clog2(MAX_BITS);
  localparam int SR_W       = 8 + ADDR_W;
  localparam int DUMMY_LAST = (DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0;

  typedef enum logic [3:0] {
    IDLE, RANGE_ERR, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, CS_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              ck_q, ck_d;
  logic              cs_q, cs_d;
  logic              io0_q, io0_d;
  logic [3:0]        iot_q, iot_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [31:0]       rx_q, rx_d;
  logic              half_end, timed, sck_on, ck_rise, ck_fall;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // Nibbles arrive byte 0 first; the word is returned little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    bit_d    = bit_q;
    ck_d     = ck_q;
    cs_d     = cs_q;
    io0_d    = io0_q;
    iot_d    = iot_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    sr_d     = sr_q;
    rx_d     = rx_q;

    half_end = (div_q == DIV_W'(CLK_DIV - 1));
    timed    = (state_q != IDLE) && (state_q != RANGE_ERR);
    sck_on   = (state_q == CMD) || (state_q == ADDR) || (state_q == DUMMY) || (state_q == DATA);
    ck_rise  = sck_on && half_end && !ck_q;
    ck_fall  = sck_on && half_end && ck_q;

    if (timed && !half_end) div_d = div_q + 1'b1;
    if (sck_on && half_end) ck_d = ~ck_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (|(addr_i >> ADDR_W)) begin
            state_d = RANGE_ERR;
          end else begin
            state_d = CS_SETUP;
            cs_d    = 1'b0;
            sr_d    = {READ_CMD, addr_i[ADDR_W-1:2], 2'b00};
          end
        end
      end
      RANGE_ERR: begin
        rvalid_d = 1'b1;
        err_d    = 1'b1;
        state_d  = IDLE;
      end
      CS_SETUP: begin
        if (half_end) begin
          state_d = CMD;
          bit_d   = '0;
          io0_d   = sr_q[SR_W-1];
          iot_d   = 4'b1110;
        end
      end
      CMD, ADDR: begin
        // Next serial bit is presented as SCK falls, i.e. at the start of the low half.
        if (ck_fall) begin
          sr_d  = sr_q << 1;
          io0_d = sr_q[SR_W-2];
          bit_d = bit_q + 1'b1;
          if (state_q == CMD && bit_q == BIT_W'(7)) begin
            state_d = ADDR;
            bit_d   = '0;
          end else if (state_q == ADDR && bit_q == BIT_W'(ADDR_W - 1)) begin
            state_d = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
            bit_d   = '0;
            io0_d   = 1'b0;
            iot_d   = 4'hF;
          end
        end
      end
      DUMMY: begin
        if (ck_fall) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(DUMMY_LAST)) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (ck_rise) rx_d = {rx_q[27:0], qspi_io_i};
        if (ck_fall) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(7)) begin
            state_d = CS_HOLD;
            bit_d   = '0;
          end
        end
      end
      CS_HOLD: begin
        if (half_end) begin
          state_d  = CS_IDLE;
          cs_d     = 1'b1;
          rvalid_d = 1'b1;
          err_d    = 1'b0;
          rdata_d  = byte_swap(rx_q);
        end
      end
      CS_IDLE: begin
        if (half_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      ck_q     <= 1'b0;
      cs_q     <= 1'b1;
      io0_q    <= 1'b0;
      iot_q    <= 4'hF;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      ck_q     <= ck_d;
      cs_q     <= cs_d;
      io0_q    <= io0_d;
      iot_q    <= iot_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Shift registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    rx_q <= rx_d;
  end

  assign ready_o   = (state_q == IDLE);
  assign rvalid_o  = rvalid_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign qspi_io_o = {3'b000, io0_q};
  assign qspi_io_t = iot_q;
  assign qspi_ck_o = ck_q;
  assign qspi_cs_o = cs_q;

endmodule

// File: doc/qspi_flash_read_ctrl.md
Name: qspi_flash_read_ctrl

Overview:
- Storage-side stage directly downstream of the mmu.
- Converts single-word read requests from the mmu into SPI-mode-0 Quad Output Fast Read (0x6B) transactions on the external storage QSPI pins.
- Returns one 32-bit word per request with a single-cycle valid pulse.
- Read-only; one outstanding request at a time.

Parameters:
- CLK_DIV, 1, clk cycles per SCK half-period (>=1).
- DUMMY_CYCLES, 8, SCK cycles between address and data.
- ADDR_W, 24, flash byte-address width.
- READ_CMD, 8'h6B, command byte sent on io[0].

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- req_i  input  1  read request
- addr_i  input  32  byte address; bits [1:0] ignored (word-aligned)
- ready_o  output  1  request accepted when req_i && ready_o at a clk edge
- rvalid_o  output  1  one-cycle response strobe
- err_o  output  1  valid with rvalid_o; address out of range
- rdata_o  output  32  read word, held until next rvalid_o
- qspi_io_i  input  4  data from flash
- qspi_io_o  output  4  data to flash
- qspi_io_t  output  4  per-bit tristate, 1 = input
- qspi_ck_o  output  1  SCK, idle low
- qspi_cs_o  output  1  chip select, active low

Behaviour:
- Reset (rst=0, asynchronous) drives idle outputs immediately:
  - ready_o=1, rvalid_o=0, err_o=0, rdata_o=0
  - cs_o=1, ck_o=0, io_o=0, io_t=4'hF
  - FSM to IDLE, counters cleared.
- Reset mid-transaction aborts it: cs_o high at once, no rvalid_o for the dropped request.
- FSM states: IDLE, RANGE_ERR, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, CS_IDLE.
  - ready_o=1 only in IDLE.
- IDLE, request accepted with addr_i[31:ADDR_W] != 0 -> RANGE_ERR:
  - Next cycle rvalid_o=1, err_o=1, rdata_o unchanged, no pin activity.
  - Then IDLE.
- IDLE, request accepted and in range:
  - Latch {addr_i[ADDR_W-1:2],2'b00}.
  - cs_o low at that edge -> CS_SETUP (CLK_DIV cycles, ck low).
- SCK cycle structure: low half (CLK_DIV clks) then high half (CLK_DIV clks).
  - Outputs change only at the start of the low half.
  - Inputs are sampled at the clk edge where ck_o goes 0->1.
- CMD: 8 SCK cycles, READ_CMD MSB first on io_o[0]; io_t=4'b1110, io_o[3:1]=0.
- ADDR: ADDR_W SCK cycles, MSB first on io_o[0]; io_t=4'b1110.
- DUMMY: DUMMY_CYCLES SCK cycles; io_t=4'hF. DUMMY_CYCLES=0 skips the state.
- DATA: 8 SCK cycles, 4 bits per cycle from io_i[3:0].
  - Each byte arrives high nibble first.
  - Byte k (address base+k) lands in rdata_o[8k+7:8k] (little-endian word).
- CS_HOLD: CLK_DIV cycles, ck low. At its end:
  - cs_o=1, rvalid_o=1 for one cycle, err_o=0, rdata_o updated in the same cycle.
- CS_IDLE: CLK_DIV cycles of cs high (minimum deselect time), then IDLE.
- Latency: N = 40+DUMMY_CYCLES SCK cycles (with ADDR_W=24).
  - cs_o low exactly CLK_DIV*(2N+2) clk cycles.
  - rvalid_o rises CLK_DIV*(2N+2) edges after the accept edge.
  - Next accept possible CLK_DIV cycles after rvalid_o.
- req_i while busy is ignored (ready_o=0); the requester must hold req_i.
- X on qspi_io_i during DATA propagates to rdata_o; no masking.

Test Plan:
- Reset, no request -> ready_o=1, cs_o=1, ck_o=0, io_t=4'hF, rvalid_o=0 held for 50 cycles.
- CLK_DIV=1, DUMMY=8, flash bytes at 0x002000 = 11 22 33 44; req addr 0x0000_2000 ->
  - io[0] serial stream 0x6B then 0x002000.
  - cs_o low 98 cycles, rvalid_o at edge 98.
  - rdata_o=0x44332211, err_o=0.
- Same flash, req addr 0x0000_2003 -> aligned to 0x002000, rdata_o=0x44332211.
- req addr 0x0100_0000 -> rvalid_o+err_o one cycle after accept, cs_o never falls, rdata_o unchanged.
- CLK_DIV=2, DUMMY=0, back-to-back reads of 0x000000 and 0x000004 ->
  - cs_o low 164 cycles each, with at least 2 cycles high between them.
  - ready_o=0 throughout each transaction.
- rst asserted during DATA phase of a read -> cs_o=1 within the same time step, no rvalid_o; a subsequent read returns correct data.
